dpc_protmon: RTL and testbench
==============================

Name: dpc_protmon

Overview:
- Synthesisable, parametrised runtime protocol monitor for N datapath-controller channels.
- Successor to the single-channel simulation-only dmem-shift check. Adds per-channel request tracking, an extready watchdog, sticky error flags, saturating violation counters, first-error capture and an interrupt.
- Sits beside the datapath controllers, observes only, and drives a status/irq interface to the register block.

Parameters:
- CHANNELS, 4, number of monitored channels (1..16).
- CNT_W, 8, width of each per-channel saturating violation counter.
- WDOG_CYCLES, 64, maximum consecutive WAIT cycles before timeout (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_in  in  CHANNELS  per-channel transfer request (ul or dl), sampled at posedge.
- extready_in  in  CHANNELS  per-channel external ready.
- shift_in  in  CHANNELS  per-channel dmem SHIFT command issued this cycle.
- done_in  in  CHANNELS  per-channel transfer complete.
- clear_in  in  1  synchronous clear of all flags, counters, first-error capture and channel FSMs.
- err_flags_out  out  CHANNELS*3  sticky flags per channel: bit0 SHIFT_NOTREADY, bit1 SHIFT_NOREQ, bit2 TIMEOUT.
- err_cnt_out  out  CHANNELS*CNT_W  per-channel violation counts.
- first_err_valid_out  out  1  first-error capture valid.
- first_err_chan_out  out  $clog2(CHANNELS) (min 1)  channel of first error.
- first_err_code_out  out  2  code of first error: 0 SHIFT_NOTREADY, 1 SHIFT_NOREQ, 2 TIMEOUT.
- irq_out  out  1  registered OR of all err_flags_out bits.

Behaviour:
- Reset: all outputs 0; all channel FSMs IDLE; watchdog counters 0.
- Per-channel FSM, states IDLE, WAIT, RUN, TIMEOUT:
  - IDLE: req_in goes to RUN if extready_in=1, else to WAIT.
  - WAIT: extready_in=1 goes to RUN. Otherwise the watchdog increments. When it reaches WDOG_CYCLES-1 while extready_in is still 0, the FSM goes to TIMEOUT and raises the TIMEOUT violation. done_in goes to IDLE (done_in has priority).
  - RUN: done_in goes to IDLE. extready_in=0 goes to WAIT.
  - TIMEOUT: stays until done_in, then goes to IDLE. The TIMEOUT violation is raised once per entry only.
- Watchdog: cleared on every entry to WAIT and on leaving WAIT.
- Violations, evaluated every cycle against the current state:
  - SHIFT_NOTREADY: shift_in=1 and extready_in=0.
  - SHIFT_NOREQ: shift_in=1 and state IDLE and req_in=0.
  - Both may fire in the same cycle.
- Flags are sticky and visible one cycle after the violating sample edge.
- Counter: increments by exactly 1 in any cycle with at least one violation on that channel, regardless of how many fired. It saturates at all-ones and never wraps.
- First-error capture:
  - Loads only while first_err_valid_out=0.
  - On simultaneous violations, the lowest channel index wins, then the lowest code.
  - Holds until clear_in.
- irq_out: set one cycle after the first flag sets.
- clear_in:
  - Wins over violations detected in the same cycle; those are dropped.
  - All channel FSMs return to IDLE.
  - Outputs read 0 on the following cycle.
- Asynchronous reset mid-transfer: immediate return to reset state; no violation is recorded.
- Inputs are not checked for protocol legality beyond the rules above. X on inputs is not propagated to flags.

Optional Feature:
- Macro DPC_PROTMON_SVA_EN.
- When defined (and not SYNTHESIS): the module also contains concurrent assertions, disabled while rst_n=0, that $error on each violation with channel number. It also carries cover properties for each FSM transition and for counter saturation.
- When undefined: pure RTL monitor, identical outputs, no assertions.

Decomposition:
- Shared package additions:
  - protmon_err_e enum (2-bit codes above).
  - protmon_fsm_t enum (IDLE, WAIT, RUN, TIMEOUT).
  - Constant PROTMON_NERR=3.
- Sub-module dpc_protmon_chan, one instance per channel via generate:
  - Contains the FSM, watchdog, flags and counter.
  - Outputs a 3-bit violation-pulse vector.
- Top level contains first-error arbitration, irq and clear fanout.

Test Plan:
- Ch0: req_in=1, extready_in=0, shift_in=1 in WAIT -> next cycle err_flags bit0=1, err_cnt[0]=1, first_err chan 0 code 0, irq_out=1 one cycle later.
- Ch2: shift_in=1 while IDLE, req_in=0, extready_in=0 -> bits 0 and 1 of ch2 set, err_cnt[2]=1 (not 2), first code 0.
- Ch1: req held, extready_in=0 for 64 cycles (WDOG_CYCLES=64) -> TIMEOUT entered, bit2 set, counter +1 exactly once; done_in -> IDLE.
- Ch1 and ch3 violate in the same cycle -> first_err_chan=1. A later ch0 violation leaves the capture unchanged.
- CNT_W=4: 20 violating cycles on ch0 -> err_cnt[0]=15, no wrap.
- clear_in coincident with a ch0 violation -> all outputs 0 the next cycle. rst_n pulsed low mid-RUN -> outputs 0 immediately, FSM IDLE.

Source files
------------

// File: rtl/dpc_protmon_pkg.sv
// Shared types and constants for the dpc_protmon datapath-controller protocol monitor.
package dpc_protmon_pkg;

  localparam int PROTMON_NERR = 3;

  typedef enum logic [1:0] {
    ERR_SHIFT_NOTREADY = 2'd0,
    ERR_SHIFT_NOREQ    = 2'd1,
    ERR_TIMEOUT        = 2'd2
  } protmon_err_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RUN     = 2'd2,
    ST_TIMEOUT = 2'd3
  } protmon_fsm_t;

  // Channel index width, never narrower than one bit.
  function automatic int protmon_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lowest-numbered violation code present in a pulse vector.
  function automatic protmon_err_e protmon_first_code(input logic [PROTMON_NERR-1:0] viol);
    protmon_err_e code;
    if (viol[0]) begin
      code = ERR_SHIFT_NOTREADY;
    end else if (viol[1]) begin
      code = ERR_SHIFT_NOREQ;
    end else begin
      code = ERR_TIMEOUT;
    end
    return code;
  endfunction

endpackage

// File: rtl/dpc_protmon_if.sv
// Observation and status bundle between the datapath controllers, the monitor and the register block.
interface dpc_protmon_if
  import dpc_protmon_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  localparam int CH_W = protmon_idx_w(CHANNELS);

  logic [CHANNELS-1:0]              req_in;
  logic [CHANNELS-1:0]              extready_in;
  logic [CHANNELS-1:0]              shift_in;
  logic [CHANNELS-1:0]              done_in;
  logic                             clear_in;
  logic [CHANNELS*PROTMON_NERR-1:0] err_flags_out;
  logic [CHANNELS*CNT_W-1:0]        err_cnt_out;
  logic                             first_err_valid_out;
  logic [CH_W-1:0]                  first_err_chan_out;
  logic [1:0]                       first_err_code_out;
  logic                             irq_out;

  modport master (
    output req_in, extready_in, shift_in, done_in, clear_in,
    input  err_flags_out, err_cnt_out, first_err_valid_out,
           first_err_chan_out, first_err_code_out, irq_out
  );

  modport slave (
    input  req_in, extready_in, shift_in, done_in, clear_in,
    output err_flags_out, err_cnt_out, first_err_valid_out,
           first_err_chan_out, first_err_code_out, irq_out
  );
endinterface

// File: rtl/dpc_protmon_chan.sv
// One monitored channel: transfer FSM, extready watchdog, sticky flags, saturating counter.
// Its assertion checker is attached from the top when DPC_PROTMON_SVA_EN is defined.
module dpc_protmon_chan
  import dpc_protmon_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    req,
  input  logic                    extready,
  input  logic                    shift,
  input  logic                    done,
  output logic [PROTMON_NERR-1:0] viol,
  output logic [PROTMON_NERR-1:0] flags,
  output logic [CNT_W-1:0]        cnt
);
  localparam int WD_W = $clog2(WDOG_CYCLES);
  // The increment that lands on WDOG_CYCLES-1 is the one that times out.
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WDOG_CYCLES - 2);

  protmon_fsm_t            state_r, state_nxt_s;
  logic [WD_W-1:0]         wdog_r, wdog_nxt_s;
  logic                    timeout_s;
  logic [PROTMON_NERR-1:0] viol_s;
  logic [PROTMON_NERR-1:0] flags_r;
  logic [CNT_W-1:0]        cnt_r;

  // Next-state and watchdog; the watchdog is zero unless staying in WAIT.
  always_comb begin
    state_nxt_s = state_r;
    wdog_nxt_s  = {WD_W{1'b0}};
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req && extready) begin
          state_nxt_s = ST_RUN;
        end else if (req) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (done) begin
          state_nxt_s = ST_IDLE;
        end else if (extready) begin
          state_nxt_s = ST_RUN;
        end else if (wdog_r == WD_LIMIT) begin
          state_nxt_s = ST_TIMEOUT;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
          wdog_nxt_s  = wdog_r + WD_W'(1);
        end
      end
      ST_RUN: begin
        if (done) begin
          state_nxt_s = ST_IDLE;
        end else if (!extready) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_TIMEOUT: begin
        if (done) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_TIMEOUT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Violation detection; written as ifs so unknown inputs resolve to "no violation".
  always_comb begin
    viol_s = {PROTMON_NERR{1'b0}};
    if (shift && !extready) begin
      viol_s[0] = 1'b1;
    end else begin
      viol_s[0] = 1'b0;
    end
    if (shift && !req && (state_r == ST_IDLE)) begin
      viol_s[1] = 1'b1;
    end else begin
      viol_s[1] = 1'b0;
    end
    viol_s[2] = timeout_s;
  end

  // State, watchdog, sticky flags and saturating counter; clear wins over violations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      wdog_r  <= {WD_W{1'b0}};
      flags_r <= {PROTMON_NERR{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else if (clear) begin
      state_r <= ST_IDLE;
      wdog_r  <= {WD_W{1'b0}};
      flags_r <= {PROTMON_NERR{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      wdog_r  <= wdog_nxt_s;
      flags_r <= flags_r | viol_s;
      if ((viol_s != {PROTMON_NERR{1'b0}}) && (cnt_r != {CNT_W{1'b1}})) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign viol  = clear ? {PROTMON_NERR{1'b0}} : viol_s;
  assign flags = flags_r;
  assign cnt   = cnt_r;

endmodule

// File: rtl/dpc_protmon.sv
// N-channel datapath-controller protocol monitor: first-error arbitration, irq and clear fanout.
// Define DPC_PROTMON_SVA_EN (non-synthesis builds) to add per-channel assertions and covers.
`ifdef DPC_PROTMON_SVA_EN
`ifndef SYNTHESIS
module dpc_protmon_chk
  import dpc_protmon_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int CHAN_IDX = 0
) (
  input logic                    clk,
  input logic                    rst_n,
  input protmon_fsm_t            state,
  input logic [PROTMON_NERR-1:0] viol,
  input logic [CNT_W-1:0]        cnt
);
  a_notready: assert property (@(posedge clk) disable iff (!rst_n) !viol[0])
    else $error("dpc_protmon ch%0d SHIFT_NOTREADY", CHAN_IDX);
  a_noreq:    assert property (@(posedge clk) disable iff (!rst_n) !viol[1])
    else $error("dpc_protmon ch%0d SHIFT_NOREQ", CHAN_IDX);
  a_timeout:  assert property (@(posedge clk) disable iff (!rst_n) !viol[2])
    else $error("dpc_protmon ch%0d TIMEOUT", CHAN_IDX);

  c_idle_wait: cover property (@(posedge clk) disable iff (!rst_n) state == ST_IDLE ##1 state == ST_WAIT);
  c_idle_run:  cover property (@(posedge clk) disable iff (!rst_n) state == ST_IDLE ##1 state == ST_RUN);
  c_wait_run:  cover property (@(posedge clk) disable iff (!rst_n) state == ST_WAIT ##1 state == ST_RUN);
  c_wait_idle: cover property (@(posedge clk) disable iff (!rst_n) state == ST_WAIT ##1 state == ST_IDLE);
  c_wait_to:   cover property (@(posedge clk) disable iff (!rst_n) state == ST_WAIT ##1 state == ST_TIMEOUT);
  c_run_idle:  cover property (@(posedge clk) disable iff (!rst_n) state == ST_RUN ##1 state == ST_IDLE);
  c_run_wait:  cover property (@(posedge clk) disable iff (!rst_n) state == ST_RUN ##1 state == ST_WAIT);
  c_to_idle:   cover property (@(posedge clk) disable iff (!rst_n) state == ST_TIMEOUT ##1 state == ST_IDLE);
  c_cnt_sat:   cover property (@(posedge clk) disable iff (!rst_n) cnt == {CNT_W{1'b1}});
endmodule
`endif
`endif

module dpc_protmon
  import dpc_protmon_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 8,
  parameter int WDOG_CYCLES = 64
) (
  input logic          clk,
  input logic          rst_n,
  dpc_protmon_if.slave bus
);
  localparam int CH_W = protmon_idx_w(CHANNELS);

  logic [PROTMON_NERR-1:0]          viol_s  [CHANNELS];
  logic [PROTMON_NERR-1:0]          flags_s [CHANNELS];
  logic [CNT_W-1:0]                 cnt_s   [CHANNELS];
  logic [CHANNELS*PROTMON_NERR-1:0] flags_all_s;
  logic [CHANNELS*CNT_W-1:0]        cnt_all_s;

  logic                             sel_found_s;
  logic [CH_W-1:0]                  sel_chan_s;
  protmon_err_e                     sel_code_s;

  logic                             fe_valid_r;
  logic [CH_W-1:0]                  fe_chan_r;
  protmon_err_e                     fe_code_r;
  logic                             irq_r;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    dpc_protmon_chan #(
      .CNT_W       (CNT_W),
      .WDOG_CYCLES (WDOG_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (bus.clear_in),
      .req      (bus.req_in[c]),
      .extready (bus.extready_in[c]),
      .shift    (bus.shift_in[c]),
      .done     (bus.done_in[c]),
      .viol     (viol_s[c]),
      .flags    (flags_s[c]),
      .cnt      (cnt_s[c])
    );

    assign flags_all_s[c*PROTMON_NERR +: PROTMON_NERR] = flags_s[c];
    assign cnt_all_s[c*CNT_W +: CNT_W]                 = cnt_s[c];

`ifdef DPC_PROTMON_SVA_EN
`ifndef SYNTHESIS
    dpc_protmon_chk #(
      .CNT_W    (CNT_W),
      .CHAN_IDX (c)
    ) u_chk (
      .clk   (clk),
      .rst_n (rst_n),
      .state (u_chan.state_r),
      .viol  (viol_s[c]),
      .cnt   (cnt_s[c])
    );
`endif
`endif
  end

  // Pick the lowest violating channel, then its lowest violation code.
  always_comb begin
    sel_found_s = 1'b0;
    sel_chan_s  = {CH_W{1'b0}};
    sel_code_s  = ERR_SHIFT_NOTREADY;
    for (int c = 0; c < CHANNELS; c++) begin
      if (!sel_found_s && (viol_s[c] != {PROTMON_NERR{1'b0}})) begin
        sel_found_s = 1'b1;
        sel_chan_s  = CH_W'(c);
        sel_code_s  = protmon_first_code(viol_s[c]);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // First-error capture and irq; irq follows the flag registers by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fe_valid_r <= 1'b0;
      fe_chan_r  <= {CH_W{1'b0}};
      fe_code_r  <= ERR_SHIFT_NOTREADY;
      irq_r      <= 1'b0;
    end else if (bus.clear_in) begin
      fe_valid_r <= 1'b0;
      fe_chan_r  <= {CH_W{1'b0}};
      fe_code_r  <= ERR_SHIFT_NOTREADY;
      irq_r      <= 1'b0;
    end else begin
      irq_r <= |flags_all_s;
      if (!fe_valid_r && sel_found_s) begin
        fe_valid_r <= 1'b1;
        fe_chan_r  <= sel_chan_s;
        fe_code_r  <= sel_code_s;
      end
    end
  end

  assign bus.err_flags_out       = flags_all_s;
  assign bus.err_cnt_out         = cnt_all_s;
  assign bus.first_err_valid_out = fe_valid_r;
  assign bus.first_err_chan_out  = fe_chan_r;
  assign bus.first_err_code_out  = fe_code_r;
  assign bus.irq_out             = irq_r;

endmodule

// File: tb/tb_dpc_protmon.sv
// Self-checking bench for dpc_protmon: transfer-level reference model plus directed scenarios.
module tb_dpc_protmon;

  localparam int CH   = 4;
  localparam int CW   = 4;
  localparam int WD   = 64;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst_n;

  dpc_protmon_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

  dpc_protmon #(.CHANNELS(CH), .CNT_W(CW), .WDOG_CYCLES(WD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: a channel is either free or inside a transfer; inside, it is stalled
  // for m_stall consecutive not-ready samples, or has timed out.
  bit       m_busy  [CH];
  bit       m_to    [CH];
  int       m_stall [CH];
  bit [2:0] m_flags [CH];
  int       m_cnt   [CH];
  bit       m_fv;
  int       m_fc;
  int       m_fcode;
  bit       m_irq;

  logic [15:0] vecs [12] = '{16'h0013, 16'h0020, 16'h0100, 16'h1000,
                             16'h0224, 16'h2040, 16'h4440, 16'h0880,
                             16'h0888, 16'h0800, 16'h8000, 16'h0FF0};

  task automatic chk(input string name, input int ch, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s ch%0d: got %0h expected %0h at %0t", name, ch, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_busy[c] = 1'b0; m_to[c] = 1'b0; m_stall[c] = 0; m_flags[c] = 3'b000; m_cnt[c] = 0;
    end
    m_fv = 1'b0; m_fc = 0; m_fcode = 0; m_irq = 1'b0;
  endtask

  // Advance the model across one sampling edge using the inputs currently driven.
  task automatic model_step();
    bit [2:0] v;
    bit found;
    bit r, e, s, d;
    if (!rst_n || bus.clear_in) begin
      model_reset();
      return;
    end
    m_irq = 1'b0;
    for (int c = 0; c < CH; c++) m_irq = m_irq | (m_flags[c] != 3'b000);
    found = 1'b0;
    for (int c = 0; c < CH; c++) begin
      r = bus.req_in[c]; e = bus.extready_in[c]; s = bus.shift_in[c]; d = bus.done_in[c];
      v = 3'b000;
      if (s && !e) v[0] = 1'b1;
      if (s && !m_busy[c] && !r) v[1] = 1'b1;
      if (!m_busy[c]) begin
        if (r) begin m_busy[c] = 1'b1; m_stall[c] = e ? 0 : 1; end
      end else if (m_to[c]) begin
        if (d) begin m_busy[c] = 1'b0; m_to[c] = 1'b0; end
      end else if (d) begin
        m_busy[c] = 1'b0; m_stall[c] = 0;
      end else if (e) begin
        m_stall[c] = 0;
      end else begin
        m_stall[c]++;
        if (m_stall[c] >= WD) begin v[2] = 1'b1; m_to[c] = 1'b1; m_stall[c] = 0; end
      end
      m_flags[c] = m_flags[c] | v;
      if (v != 3'b000 && m_cnt[c] < CMAX) m_cnt[c]++;
      if (!m_fv && !found && v != 3'b000) begin
        found = 1'b1; m_fc = c; m_fcode = v[0] ? 0 : (v[1] ? 1 : 2);
      end
    end
    if (found) m_fv = 1'b1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < CH; c++) begin
        chk("flags", c, 32'(bus.err_flags_out[c*3 +: 3]), 32'(m_flags[c]));
        chk("cnt",   c, 32'(bus.err_cnt_out[c*CW +: CW]), 32'(m_cnt[c]));
      end
      chk("fe_valid", 0, 32'(bus.first_err_valid_out), 32'(m_fv));
      chk("fe_chan",  0, 32'(bus.first_err_chan_out),  32'(m_fc));
      chk("fe_code",  0, 32'(bus.first_err_code_out),  32'(m_fcode));
      chk("irq",      0, 32'(bus.irq_out),             32'(m_irq));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      model_step();
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_flags"}, 0, 32'(bus.err_flags_out),       32'h0);
    chk({tag, "_cnt"},   0, 32'(bus.err_cnt_out),         32'h0);
    chk({tag, "_fev"},   0, 32'(bus.first_err_valid_out), 32'h0);
    chk({tag, "_fec"},   0, 32'(bus.first_err_chan_out),  32'h0);
    chk({tag, "_fcode"}, 0, 32'(bus.first_err_code_out),  32'h0);
    chk({tag, "_irq"},   0, 32'(bus.irq_out),             32'h0);
  endtask

  task automatic pulse_clear();
    bus.clear_in = 1'b1;
    tick(1);
    bus.clear_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_in = '0; bus.extready_in = '0; bus.shift_in = '0; bus.done_in = '0; bus.clear_in = 1'b0;
    model_reset();
    chk_en = 1'b1;
    tick(2);
    check_zero("reset");
    rst_n = 1'b1;
    tick(1);

    // ch0: shift while waiting for extready
    bus.req_in = 4'b0001; tick(1);
    bus.req_in = 4'b0000; bus.shift_in = 4'b0001; tick(1);
    bus.shift_in = 4'b0000;
    chk("t1_flags", 0, 32'(bus.err_flags_out), 32'h001);
    chk("t1_cnt",   0, 32'(bus.err_cnt_out[3:0]), 32'd1);
    chk("t1_fev",   0, 32'(bus.first_err_valid_out), 32'd1);
    chk("t1_fcode", 0, 32'(bus.first_err_code_out), 32'd0);
    chk("t1_irq0",  0, 32'(bus.irq_out), 32'd0);
    tick(1);
    chk("t1_irq1",  0, 32'(bus.irq_out), 32'd1);
    bus.done_in = 4'b0001; tick(1); bus.done_in = 4'b0000;
    pulse_clear();
    check_zero("clr1");

    // ch2: shift while idle with no request and no extready
    bus.shift_in = 4'b0100; tick(1); bus.shift_in = 4'b0000;
    chk("t2_flags", 2, 32'(bus.err_flags_out[8:6]), 32'h3);
    chk("t2_cnt",   2, 32'(bus.err_cnt_out[11:8]), 32'd1);
    chk("t2_fec",   2, 32'(bus.first_err_chan_out), 32'd2);
    chk("t2_fcode", 2, 32'(bus.first_err_code_out), 32'd0);
    pulse_clear();

    // ch1: watchdog timeout after 64 not-ready samples
    bus.req_in = 4'b0010; tick(63);
    chk("t3_pre",   1, 32'(bus.err_flags_out[5:3]), 32'h0);
    tick(1);
    chk("t3_flags", 1, 32'(bus.err_flags_out[5:3]), 32'h4);
    chk("t3_fcode", 1, 32'(bus.first_err_code_out), 32'd2);
    bus.req_in = 4'b0000; tick(5);
    chk("t3_once",  1, 32'(bus.err_cnt_out[7:4]), 32'd1);
    bus.done_in = 4'b0010; tick(1); bus.done_in = 4'b0000;
    bus.shift_in = 4'b0010; bus.extready_in = 4'b0010; tick(1);
    bus.shift_in = 4'b0000; bus.extready_in = 4'b0000;
    chk("t3_idle",  1, 32'(bus.err_flags_out[5:3]), 32'h6);
    chk("t3_cnt2",  1, 32'(bus.err_cnt_out[7:4]), 32'd2);
    pulse_clear();

    // ch1 and ch3 together, then ch0 later
    bus.shift_in = 4'b1010; tick(1);
    bus.shift_in = 4'b0001; tick(1);
    bus.shift_in = 4'b0000;
    chk("t4_fec",   1, 32'(bus.first_err_chan_out), 32'd1);
    chk("t4_fcode", 1, 32'(bus.first_err_code_out), 32'd0);
    chk("t4_ch3",   3, 32'(bus.err_flags_out[11:9]), 32'h3);
    chk("t4_ch0",   0, 32'(bus.err_flags_out[2:0]), 32'h3);
    pulse_clear();

    // ch0: counter saturation
    bus.shift_in = 4'b0001; tick(20); bus.shift_in = 4'b0000;
    chk("t5_sat",   0, 32'(bus.err_cnt_out[3:0]), 32'd15);

    // clear coincident with a violation
    bus.clear_in = 1'b1; bus.shift_in = 4'b0001; tick(1);
    bus.clear_in = 1'b0; bus.shift_in = 4'b0000;
    check_zero("t6");

    // async reset in the middle of a ch0 transfer
    bus.shift_in = 4'b1000; tick(1); bus.shift_in = 4'b0000;
    bus.req_in = 4'b0001; bus.extready_in = 4'b0001; tick(3); bus.req_in = 4'b0000;
    #2; rst_n = 1'b0; model_reset();
    #1; check_zero("t7_arst");
    @(negedge clk); #1;
    rst_n = 1'b1;
    bus.shift_in = 4'b0001; tick(1);
    bus.shift_in = 4'b0000; bus.extready_in = 4'b0000;
    chk("t7_idle",  0, 32'(bus.err_flags_out[2:0]), 32'h2);
    pulse_clear();

    // mixed directed vectors {done, shift, extready, req}
    for (int i = 0; i < 12; i++) begin
      bus.done_in = vecs[i][15:12]; bus.shift_in = vecs[i][11:8];
      bus.extready_in = vecs[i][7:4]; bus.req_in = vecs[i][3:0];
      tick(1);
    end
    bus.req_in = '0; bus.extready_in = '0; bus.shift_in = '0; bus.done_in = '0;
    tick(2);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
